// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 scan-code decoder.
// Holds the decoder FSM states, the key event record and the modifier codes.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK,
      PAUSE
   } ps2_state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_event_t;

   localparam int EVT_W = $bits(key_event_t);

   localparam logic [7:0] SC_E0     = 8'hE0;
   localparam logic [7:0] SC_F0     = 8'hF0;
   localparam logic [7:0] SC_E1     = 8'hE1;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_PAUSE  = 8'h77;

   // E1 is followed by seven more bytes that carry no information of their own.
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   // Keyboard status/response bytes that never form a key event.
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
             (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

   function automatic key_event_t make_evt(input logic ext, input logic brk,
                                           input logic [7:0] code);
      key_event_t e;
      e.ext  = ext;
      e.brk  = brk;
      e.code = code;
      return e;
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO for decoded key events with a valid/ready style head.
// A push while full is accepted only when a pop frees a slot on the same edge.
module ps2_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             not_empty,
   output logic             drop
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign not_empty = (count != '0);
   assign do_pop    = pop && not_empty;
   assign do_push   = push && (!full || do_pop);
   assign drop      = push && !do_push;
   assign head      = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Turns a stream of PS/2 set-2 scan bytes into make/break key events,
// tracks modifier levels and queues events behind a valid/ready interface.
module ps2_scan_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] scan_byte,
   input  logic       scan_valid,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_brk,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [3:0] mods,
   output logic       overflow,
   output logic       proto_err
);

   ps2_state_t state, state_next;
   logic [2:0] skip, skip_next;
   logic       push_evt;
   key_event_t new_evt;
   key_event_t head_evt;
   logic       err_next;
   logic       fifo_drop;
   logic [EVT_W-1:0] head_bits;

   logic lshift, rshift, lctrl, rctrl, lalt, ralt, caps, caps_held;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         skip      <= '0;
         proto_err <= 1'b0;
      end else begin
         state     <= state_next;
         skip      <= skip_next;
         proto_err <= err_next;
      end
   end

   always_comb begin
      state_next = state;
      skip_next  = skip;
      push_evt   = 1'b0;
      new_evt    = '0;
      err_next   = 1'b0;
      if (scan_valid) begin
         case (state)
            IDLE: begin
               if (scan_byte == SC_E0) state_next = EXT;
               else if (scan_byte == SC_F0) state_next = BRK;
               else if (scan_byte == SC_E1) begin
                  state_next = PAUSE;
                  skip_next  = PAUSE_SKIP;
               end else if (!is_ignored(scan_byte)) begin
                  push_evt = 1'b1;
                  new_evt  = make_evt(1'b0, 1'b0, scan_byte);
               end
            end
            EXT: begin
               if (scan_byte == SC_F0) state_next = EXT_BRK;
               else if (scan_byte != SC_E0) begin
                  push_evt   = 1'b1;
                  new_evt    = make_evt(1'b1, 1'b0, scan_byte);
                  state_next = IDLE;
               end
            end
            BRK: begin
               if (scan_byte == SC_E0 || scan_byte == SC_E1) begin
                  err_next   = 1'b1;
                  state_next = IDLE;
               end else if (scan_byte != SC_F0) begin
                  push_evt   = 1'b1;
                  new_evt    = make_evt(1'b0, 1'b1, scan_byte);
                  state_next = IDLE;
               end
            end
            EXT_BRK: begin
               state_next = IDLE;
               if (scan_byte == SC_F0 || scan_byte == SC_E0 || scan_byte == SC_E1) begin
                  err_next = 1'b1;
               end else begin
                  push_evt = 1'b1;
                  new_evt  = make_evt(1'b1, 1'b1, scan_byte);
               end
            end
            PAUSE: begin
               skip_next = skip - 3'd1;
               if (skip <= 3'd1) begin
                  skip_next  = '0;
                  push_evt   = 1'b1;
                  new_evt    = make_evt(1'b1, 1'b0, SC_PAUSE);
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Modifiers follow decoded events directly, so a full FIFO never hides a key state change.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lshift    <= 1'b0;
         rshift    <= 1'b0;
         lctrl     <= 1'b0;
         rctrl     <= 1'b0;
         lalt      <= 1'b0;
         ralt      <= 1'b0;
         caps      <= 1'b0;
         caps_held <= 1'b0;
      end else if (push_evt) begin
         if (!new_evt.ext && new_evt.code == SC_LSHIFT) lshift <= !new_evt.brk;
         if (!new_evt.ext && new_evt.code == SC_RSHIFT) rshift <= !new_evt.brk;
         if (new_evt.code == SC_CTRL) begin
            if (new_evt.ext) rctrl <= !new_evt.brk;
            else             lctrl <= !new_evt.brk;
         end
         if (new_evt.code == SC_ALT) begin
            if (new_evt.ext) ralt <= !new_evt.brk;
            else             lalt <= !new_evt.brk;
         end
         // Typematic repeats of caps lock arrive as extra makes; only the first one toggles.
         if (!new_evt.ext && new_evt.code == SC_CAPS) begin
            if (new_evt.brk) caps_held <= 1'b0;
            else if (!caps_held) begin
               caps_held <= 1'b1;
               caps      <= !caps;
            end
         end
      end
   end

   assign mods = {caps, lalt | ralt, lctrl | rctrl, lshift | rshift};

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push_evt),
      .push_data (new_evt),
      .pop       (evt_ready),
      .head      (head_bits),
      .not_empty (evt_valid),
      .drop      (fifo_drop)
   );

   assign head_evt = key_event_t'(head_bits);
   assign evt_code = head_evt.code;
   assign evt_ext  = head_evt.ext;
   assign evt_brk  = head_evt.brk;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)       overflow <= 1'b0;
      else if (fifo_drop) overflow <= 1'b1;
   end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: expected events go into a scoreboard
// queue as bytes are driven and are matched against each handshake transfer.
module tb_ps2_scan_decoder;

   logic       clock;
   logic       reset_n;
   logic [7:0] scan_byte;
   logic       scan_valid;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_brk;
   logic       evt_valid;
   logic       evt_ready;
   logic [3:0] mods;
   logic       overflow;
   logic       proto_err;

   int total = 0;
   int bad   = 0;
   logic [9:0] expq [$];

   ps2_scan_decoder #(.FIFO_DEPTH(4)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .scan_byte  (scan_byte),
      .scan_valid (scan_valid),
      .evt_code   (evt_code),
      .evt_ext    (evt_ext),
      .evt_brk    (evt_brk),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .mods       (mods),
      .overflow   (overflow),
      .proto_err  (proto_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
      expq.push_back({ext, brk, code});
   endtask

   // Drives one strobed byte; consecutive calls give back-to-back strobes.
   task automatic apply_stimulus(input logic [7:0] b);
      scan_byte  = b;
      scan_valid = 1'b1;
      @(posedge clock);
      #1;
      scan_valid = 1'b0;
      scan_byte  = 8'h00;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && expq.size() != 0; i++) begin
         @(posedge clock);
         #1;
      end
      repeat (3) @(posedge clock);
      #1;
      check_output("drain_queue", expq.size(), 0);
      check_output("drain_valid", evt_valid, 1'b0);
   endtask

   // Scoreboard: each accepted head event must be the oldest expectation.
   always @(negedge clock) begin
      if (reset_n && evt_valid && evt_ready) begin
         if (expq.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL unexpected_evt observed=%0h expected=none",
                   {evt_ext, evt_brk, evt_code});
         end else begin
            check_output("evt", {evt_ext, evt_brk, evt_code}, expq.pop_front());
         end
      end
   end

   initial begin
      reset_n    = 1'b0;
      scan_byte  = 8'h00;
      scan_valid = 1'b0;
      evt_ready  = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check_output("rst_valid", evt_valid, 1'b0);
      check_output("rst_head", {evt_ext, evt_brk, evt_code}, 10'h000);
      check_output("rst_mods", mods, 4'h0);
      check_output("rst_ovf", overflow, 1'b0);
      check_output("rst_err", proto_err, 1'b0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // make then break, plus ignored status bytes
      expect_evt(1'b0, 1'b0, 8'h1C);
      apply_stimulus(8'h1C);
      check_output("push_latency", evt_valid, 1'b1);
      expect_evt(1'b0, 1'b1, 8'h1C);
      apply_stimulus(8'hF0);
      apply_stimulus(8'h1C);
      apply_stimulus(8'hAA);
      apply_stimulus(8'hFA);
      wait_drain();

      // extended break, repeated prefixes
      expect_evt(1'b1, 1'b1, 8'h75);
      apply_stimulus(8'hE0);
      apply_stimulus(8'hF0);
      apply_stimulus(8'h75);
      expect_evt(1'b1, 1'b0, 8'h1C);
      apply_stimulus(8'hE0);
      apply_stimulus(8'hE0);
      apply_stimulus(8'h1C);
      expect_evt(1'b0, 1'b1, 8'h2A);
      apply_stimulus(8'hF0);
      apply_stimulus(8'hF0);
      apply_stimulus(8'h2A);
      wait_drain();

      // pause sequence yields one event and does not touch ctrl
      expect_evt(1'b1, 1'b0, 8'h77);
      apply_stimulus(8'hE1);
      apply_stimulus(8'h14);
      apply_stimulus(8'h77);
      apply_stimulus(8'hE1);
      apply_stimulus(8'hF0);
      apply_stimulus(8'h14);
      apply_stimulus(8'hF0);
      apply_stimulus(8'h77);
      check_output("pause_mods", mods, 4'h0);
      wait_drain();

      // modifiers: shift and caps lock with typematic repeat
      expect_evt(1'b0, 1'b0, 8'h12);
      apply_stimulus(8'h12);
      check_output("mods_shift", mods, 4'b0001);
      expect_evt(1'b0, 1'b0, 8'h58);
      apply_stimulus(8'h58);
      check_output("mods_caps_on", mods, 4'b1001);
      expect_evt(1'b0, 1'b0, 8'h58);
      apply_stimulus(8'h58);
      check_output("mods_caps_repeat", mods, 4'b1001);
      expect_evt(1'b0, 1'b1, 8'h58);
      apply_stimulus(8'hF0);
      apply_stimulus(8'h58);
      check_output("mods_caps_brk", mods, 4'b1001);
      expect_evt(1'b0, 1'b0, 8'h58);
      apply_stimulus(8'h58);
      check_output("mods_caps_off", mods, 4'b0001);
      expect_evt(1'b0, 1'b1, 8'h12);
      apply_stimulus(8'hF0);
      apply_stimulus(8'h12);
      check_output("mods_shift_rel", mods, 4'b0000);
      expect_evt(1'b1, 1'b0, 8'h14);
      apply_stimulus(8'hE0);
      apply_stimulus(8'h14);
      expect_evt(1'b0, 1'b0, 8'h11);
      apply_stimulus(8'h11);
      check_output("mods_rctrl_lalt", mods, 4'b0110);
      expect_evt(1'b1, 1'b1, 8'h14);
      apply_stimulus(8'hE0);
      apply_stimulus(8'hF0);
      apply_stimulus(8'h14);
      expect_evt(1'b0, 1'b1, 8'h11);
      apply_stimulus(8'hF0);
      apply_stimulus(8'h11);
      check_output("mods_all_rel", mods, 4'b0000);
      wait_drain();

      // overflow with a stalled consumer, then push-while-pop when full
      evt_ready = 1'b0;
      expect_evt(1'b0, 1'b0, 8'h15);
      apply_stimulus(8'h15);
      expect_evt(1'b0, 1'b0, 8'h1D);
      apply_stimulus(8'h1D);
      expect_evt(1'b0, 1'b0, 8'h24);
      apply_stimulus(8'h24);
      expect_evt(1'b0, 1'b0, 8'h2D);
      apply_stimulus(8'h2D);
      check_output("full_no_ovf", overflow, 1'b0);
      apply_stimulus(8'h2C);
      check_output("ovf_set", overflow, 1'b1);
      repeat (2) @(posedge clock);
      #1;
      check_output("head_stable", {evt_valid, evt_ext, evt_brk, evt_code}, 11'h415);
      evt_ready = 1'b1;
      expect_evt(1'b0, 1'b0, 8'h35);
      apply_stimulus(8'h35);
      wait_drain();
      check_output("ovf_sticky", overflow, 1'b1);

      // illegal prefix, then reset in the middle of a prefix
      apply_stimulus(8'hF0);
      apply_stimulus(8'hE0);
      check_output("proto_err_pulse", proto_err, 1'b1);
      @(posedge clock);
      #1;
      check_output("proto_err_clear", proto_err, 1'b0);
      apply_stimulus(8'hE0);
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_output("rst2_ovf", overflow, 1'b0);
      check_output("rst2_valid", evt_valid, 1'b0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      expect_evt(1'b0, 1'b0, 8'h1C);
      apply_stimulus(8'h1C);
      check_output("no_err_after_rst", proto_err, 1'b0);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
